fifo_ctrl_1024x32: RTL

Single-clock FIFO controller that drives the 1024x32 dual-port EBR RAM (registered write data, registered read output, unregistered addresses, 4 parity bits via EDI/EDO). It provides a write/read request interface with Full/Empty/count flags. It generates the RAM write and read addresses and enables, computes per-byte parity into EDI, and checks EDO against the returned word. Both RAM clocks are tied to this block's Clock.

---
 rtl/fifo_ctrl_1024x32.sv | 107 ++++++++++
 1 files changed

// File: rtl/fifo_ctrl_1024x32.sv
// Single-clock FIFO controller for a 1024x32 EBR RAM with registered read data.
// Optional per-byte parity generation/check is enabled by defining FIFO_PARITY_EN.
module fifo_ctrl_1024x32 #(
    parameter int WIDTH       = 32,
    parameter int AW          = 10,
    parameter int AFULL_LEVEL = 1008
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             WrReq,
    input  logic [WIDTH-1:0] Data,
    output logic             Full,
    output logic             AlmostFull,
    input  logic             RdReq,
    output logic [WIDTH-1:0] Q,
    output logic             QValid,
    output logic             Empty,
    output logic [AW:0]      Count,
    output logic             Overflow,
    output logic             Underflow,
    output logic             ParityErr,
    output logic             ParityErrSticky,
    output logic             RamWrEn,
    output logic [AW-1:0]    RamWrAddr,
    output logic [WIDTH-1:0] RamData,
    output logic [3:0]       RamEDI,
    output logic             RamRdEn,
    output logic [AW-1:0]    RamRdAddr,
    input  logic [WIDTH-1:0] RamQ,
    input  logic [3:0]       RamEDO
);

    localparam logic [AW:0] DEPTH  = (AW+1)'(2**AW);
    localparam logic [AW:0] AFULL  = (AW+1)'(AFULL_LEVEL);

    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          wr_acc, rd_acc;
    logic          qvalid, overflow, underflow;

    assign Full       = (count == DEPTH);
    assign Empty      = (count == '0);
    assign AlmostFull = (count >= AFULL);
    assign Count      = count;

    // Reset masks the enables so the RAM sees no access during a reset cycle.
    assign wr_acc = WrReq & ~Full & ~Reset;
    assign rd_acc = RdReq & ~Empty & ~Reset;

    assign RamWrEn   = wr_acc;
    assign RamRdEn   = rd_acc;
    assign RamWrAddr = wptr;
    assign RamRdAddr = rptr;
    assign RamData   = Data;
    assign Q         = RamQ;
    assign QValid    = qvalid;
    assign Overflow  = overflow;
    assign Underflow = underflow;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            qvalid    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
            if (wr_acc && !rd_acc)
                count <= count + 1'b1;
            else if (rd_acc && !wr_acc)
                count <= count - 1'b1;
            qvalid    <= rd_acc;
            overflow  <= WrReq & Full;
            underflow <= RdReq & Empty;
        end
    end

`ifdef FIFO_PARITY_EN
    function automatic logic [3:0] byte_par(input logic [31:0] d);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction

    logic sticky;

    assign RamEDI          = byte_par(Data);
    assign ParityErr       = qvalid & (byte_par(RamQ) != RamEDO);
    assign ParityErrSticky = sticky;

    always_ff @(posedge Clock) begin
        if (Reset) sticky <= 1'b0;
        else if (ParityErr) sticky <= 1'b1;
    end
`else
    logic unused_edo;

    assign unused_edo      = ^RamEDO;
    assign RamEDI          = 4'b0;
    assign ParityErr       = 1'b0;
    assign ParityErrSticky = 1'b0;
`endif

endmodule
